// File: rtl/alu_mul_seq_if.sv
// Handshake and operand/result bundle between the control unit and the sequential multiplier.
interface alu_mul_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, A, B,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, A, B,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Sequential signed multiplier: radix-4 Booth, two multiplier bits per clock,
// full 2*WIDTH-bit product delivered on HI/LO with a one-cycle done pulse.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clock,
  input logic         clear,
  alu_mul_seq_if.slave bus
);

  localparam int unsigned AccW  = WIDTH + 2;
  localparam int unsigned Steps = WIDTH / 2;
  localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [AccW-1:0] m_q, m_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic            qm1_q, qm1_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [AccW-1:0]  addend;
  logic [AccW-1:0]  sum;
  logic [AccW-1:0]  acc_sh;
  logic [WIDTH-1:0] q_sh;

  // Booth digit select; acc is two bits wider than WIDTH so +/-2M never overflows.
  always_comb begin
    addend = '0;
    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: addend = m_q;
      3'b011:         addend = m_q << 1;
      3'b100:         addend = -(m_q << 1);
      3'b101, 3'b110: addend = -m_q;
      default:        addend = '0;
    endcase
  end

  always_comb begin
    sum    = acc_q + addend;
    acc_sh = {{2{sum[AccW-1]}}, sum[AccW-1:2]};
    q_sh   = {sum[1:0], q_q[WIDTH-1:2]};
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          m_d     = {{2{bus.A[WIDTH-1]}}, bus.A};
          q_d     = bus.B;
          qm1_d   = 1'b0;
          acc_d   = '0;
          count_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = acc_sh;
        q_d   = q_sh;
        qm1_d = q_q[1];
        if (count_q == LastCnt) begin
          state_d = StDone;
          hi_d    = acc_sh[WIDTH-1:0];
          lo_d    = q_sh;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= StIdle;
      count_q <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Sequential signed multiplier for the MiniSRC ALU; the multiplicative counterpart of the combinational divider.
- Computes the full 2*WIDTH-bit two's-complement product of two WIDTH-bit operands with radix-4 Booth recoding, two multiplier bits per clock.
- Result drives the HI/LO register pair; the control unit launches it with a start pulse and waits for done.

Parameters:
WIDTH, 32, operand width in bits; must be even and >= 4

Ports:
clock  input  1  rising-edge clock
clear  input  1  asynchronous, active-low reset
start  input  1  launch request; sampled only in IDLE
A  input  WIDTH  multiplicand, signed
B  input  WIDTH  multiplier, signed
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; product valid
hi  output  WIDTH  upper half of the signed product
lo  output  WIDTH  lower half of the signed product

Behaviour:
- Reset: clock and reset are as already decided (one clock; asynchronous, active-low reset).
  - clear=0 immediately forces state=IDLE, step count=0, busy=0, done=0, hi=0, lo=0, and clears all datapath registers.
  - Takes effect regardless of state, including mid-RUN; the aborted operation is discarded.
- States:
  - IDLE: start=1 at edge k latches M=A (sign-extended to WIDTH+2 bits), Q=B, q_m1=0, acc=0, count=0 -> RUN. start=0 stays in IDLE.
  - RUN: one Booth step per edge at edges k+1 .. k+WIDTH/2. At the edge where count=WIDTH/2-1 -> DONE. Otherwise count+1.
  - DONE: done=1 for exactly one cycle -> IDLE on the next edge.
- Latency: start sampled at edge k; done high in the cycle following edge k+WIDTH/2 (k+16 for the default). busy=1 for exactly WIDTH/2 cycles.
- Booth step: examine {Q[1],Q[0],q_m1}.
  - 000 / 111: +0
  - 001 / 010: +M
  - 011: +2M
  - 100: -2M
  - 101 / 110: -M
  - Add to acc (WIDTH+2 bits, two's complement), then arithmetic-shift {acc,Q,q_m1} right by 2. q_m1 takes old Q[1].
- Width rule: acc is WIDTH+2 bits so that +/-2M for M=-2^(WIDTH-1) cannot overflow. Sign fill on the shift comes from acc MSB.
- Result:
  - On entry to DONE, hi = acc[WIDTH-1:0] and lo = Q.
  - hi/lo hold that value through IDLE until the next operation's DONE.
  - hi/lo do not change during RUN.
- Handshakes:
  - start during RUN or DONE is ignored; it is neither queued nor does it restart.
  - start held high continuously gives back-to-back operations with one IDLE cycle between DONE and the next RUN.
  - A and B are sampled only at the launch edge; later changes have no effect.
- No overflow flag. The 2*WIDTH-bit product is always exact.

Test Plan:
- 3 x 5, then -7 x 6 -> hi:lo = 0x00000000:0x0000000F after done; then 0xFFFFFFFF:0xFFFFFFD6. busy high exactly 16 cycles each; done high exactly 1 cycle.
- 0x80000000 x 0x80000000 -> 0x40000000:0x00000000. 0x80000000 x 0xFFFFFFFF -> 0x00000000:0x80000000. 0x7FFFFFFF x 0x7FFFFFFF -> 0x3FFFFFFF:0x00000001.
- Start pulse with A=2, B=3; change A/B and re-pulse start at RUN cycle 5 -> single done at cycle 16 with 0x00000000:0x00000006; no second done.
- clear=0 asynchronously at RUN cycle 8 of 1234 x -1 -> busy, done, hi, lo all 0 immediately. After release, new start with 1234 x -1 -> 0xFFFFFFFF:0xFFFFFB2E.
- start held high for 3 operations -> done pulses exactly 18 cycles apart. hi/lo stable between pulses.
- 1000 random signed operand pairs, including 0 and +/-1 -> hi:lo equals the reference 64-bit signed product on every done.
